// File: rtl/float_svm_issue.sv
// rtl/float_svm_issue.sv - credit-gated issue queue feeding a scalar-times-vector multiplier stage
module float_svm_issue #(
  parameter int VALUES_PER_LINE = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int RESULT_CREDITS  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  scalar_in,
  input  logic                         scalar_load,
  input  logic [32*VALUES_PER_LINE-1:0] vector_in,
  input  logic                         vector_valid,
  output logic                         vector_ready,
  output logic [31:0]                  mult_scalar,
  output logic [32*VALUES_PER_LINE-1:0] mult_vector,
  output logic                         mult_trigger,
  input  logic                         credit_return,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [7:0]                   credits,
  output logic                         credit_overflow,
  output logic                         idle
);

  localparam int LW = 32 * VALUES_PER_LINE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [7:0]    MAX_CRED = 8'(RESULT_CREDITS);

  // Each entry keeps its line plus the scalar that was effective when it was accepted
  logic [LW-1:0] line_mem   [FIFO_DEPTH];
  logic [31:0]   scalar_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   scalar_reg;
  logic [31:0]   eff_scalar;
  logic          push;
  logic          issue;
  logic          ret_ok;

  // Handshake, issue decision and credit-return qualification
  always_comb begin
    vector_ready = !reset && (fifo_count < DEPTH);
    push         = vector_valid && vector_ready;
    issue        = (fifo_count != '0) && (credits != 8'd0);
    eff_scalar   = scalar_load ? scalar_in : scalar_reg;
    // A return is only meaningful if a slot is actually outstanding (or one is taken this cycle)
    ret_ok       = credit_return && (issue || (credits != MAX_CRED));
    idle         = (fifo_count == '0) && (credits == MAX_CRED) && !mult_trigger;
  end

  // Entry storage; contents are don't-care until written, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      line_mem[wr_ptr]   <= vector_in;
      scalar_mem[wr_ptr] <= eff_scalar;
    end
  end

  // Pointers, occupancy, credits, scalar register and the multiplier-stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      credits         <= MAX_CRED;
      credit_overflow <= 1'b0;
      scalar_reg      <= '0;
      mult_trigger    <= 1'b0;
      mult_scalar     <= '0;
      mult_vector     <= '0;
    end else begin
      if (scalar_load) scalar_reg <= scalar_in;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);

      case ({push, issue})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      case ({issue, ret_ok})
        2'b10:   credits <= credits - 8'd1;
        2'b01:   credits <= credits + 8'd1;
        default: credits <= credits;
      endcase

      if (credit_return && !ret_ok) credit_overflow <= 1'b1;

      mult_trigger <= issue;
      if (issue) begin
        mult_scalar <= scalar_mem[rd_ptr];
        mult_vector <= line_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_float_svm_issue.sv
// tb/tb_float_svm_issue.sv - self-checking bench for float_svm_issue against a queue-based model
module tb_float_svm_issue;

  localparam int VPL   = 16;
  localparam int DEPTH = 8;
  localparam int CRED  = 16;
  localparam int LW    = 32 * VPL;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   scalar_in;
  logic          scalar_load;
  logic [LW-1:0] vector_in;
  logic          vector_valid;
  logic          vector_ready;
  logic [31:0]   mult_scalar;
  logic [LW-1:0] mult_vector;
  logic          mult_trigger;
  logic          credit_return;
  logic [3:0]    fifo_count;
  logic [7:0]    credits;
  logic          credit_overflow;
  logic          idle;

  // Free-running clock
  always #5 clk = ~clk;

  float_svm_issue #(
    .VALUES_PER_LINE(VPL),
    .FIFO_DEPTH(DEPTH),
    .RESULT_CREDITS(CRED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scalar_in(scalar_in),
    .scalar_load(scalar_load),
    .vector_in(vector_in),
    .vector_valid(vector_valid),
    .vector_ready(vector_ready),
    .mult_scalar(mult_scalar),
    .mult_vector(mult_vector),
    .mult_trigger(mult_trigger),
    .credit_return(credit_return),
    .fifo_count(fifo_count),
    .credits(credits),
    .credit_overflow(credit_overflow),
    .idle(idle)
  );

  typedef struct {
    logic [31:0]   s;
    logic [LW-1:0] v;
  } entry_t;

  entry_t        mq[$];
  int            m_cred;
  logic [31:0]   m_sreg;
  bit            m_ovf;
  bit            m_trig;
  logic [31:0]   m_ms;
  logic [LW-1:0] m_mv;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < VPL; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic quiet();
    vector_valid  = 1'b0;
    scalar_load   = 1'b0;
    credit_return = 1'b0;
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check state after it
  task automatic step();
    bit          exp_ready;
    bit          do_push;
    bit          do_issue;
    logic [31:0] eff;
    entry_t      e;
    @(negedge clk);
    exp_ready = !reset && (mq.size() < DEPTH);
    chk("vector_ready", LW'(vector_ready), LW'(exp_ready));
    do_push  = vector_valid && exp_ready;
    do_issue = (mq.size() > 0) && (m_cred > 0);
    eff      = scalar_load ? scalar_in : m_sreg;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_cred = CRED;
      m_sreg = '0;
      m_ovf  = 1'b0;
      m_trig = 1'b0;
      m_ms   = '0;
      m_mv   = '0;
    end else begin
      if (do_issue) begin
        e = mq.pop_front();
        m_trig = 1'b1;
        m_ms   = e.s;
        m_mv   = e.v;
      end else begin
        m_trig = 1'b0;
      end
      if (do_push) begin
        e.s = eff;
        e.v = vector_in;
        mq.push_back(e);
      end
      if (credit_return && !do_issue && m_cred == CRED) m_ovf = 1'b1;
      else m_cred = m_cred - int'(do_issue) + int'(credit_return);
      if (scalar_load) m_sreg = scalar_in;
    end
    #1;
    chk("mult_trigger", LW'(mult_trigger), LW'(m_trig));
    chk("mult_scalar", LW'(mult_scalar), LW'(m_ms));
    chk("mult_vector", mult_vector, m_mv);
    chk("fifo_count", LW'(fifo_count), LW'(mq.size()));
    chk("credits", LW'(credits), LW'(m_cred));
    chk("credit_overflow", LW'(credit_overflow), LW'(m_ovf));
    chk("idle", LW'(idle), LW'(mq.size() == 0 && m_cred == CRED && !m_trig));
  endtask

  initial begin
    logic [LW-1:0] line_a;
    logic [LW-1:0] line_b;
    logic [LW-1:0] ones;
    int guard;

    reset     = 1'b1;
    scalar_in = '0;
    vector_in = '0;
    quiet();
    m_cred = CRED;
    m_sreg = '0;
    m_ovf  = 1'b0;
    m_trig = 1'b0;
    m_ms   = '0;
    m_mv   = '0;
    step();
    step();
    chk("rst_fifo_count", LW'(fifo_count), LW'(0));
    chk("rst_credits", LW'(credits), LW'(16));
    chk("rst_idle", LW'(idle), LW'(1));
    chk("rst_mult_vector", mult_vector, LW'(0));
    reset = 1'b0;

    // scalar 2.0 loaded, then a line of 1.0s: trigger two cycles after accept
    scalar_in   = 32'h4000_0000;
    scalar_load = 1'b1;
    step();
    scalar_load  = 1'b0;
    ones         = {VPL{32'h3F80_0000}};
    vector_in    = ones;
    vector_valid = 1'b1;
    step();
    vector_valid = 1'b0;
    chk("lat_t1_trigger", LW'(mult_trigger), LW'(0));
    step();
    chk("lat_t2_trigger", LW'(mult_trigger), LW'(1));
    chk("lat_t2_scalar", LW'(mult_scalar), LW'(32'h4000_0000));
    chk("lat_t2_vector", mult_vector, ones);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;

    // Scalar snapshot: A takes S1, B is accepted with S2 loaded in the same cycle
    line_a      = rand_line();
    line_b      = rand_line();
    scalar_in   = 32'h3F00_0000;
    scalar_load = 1'b1;
    step();
    scalar_load  = 1'b0;
    scalar_in    = 32'hDEAD_BEEF;
    vector_in    = line_a;
    vector_valid = 1'b1;
    step();
    scalar_in   = 32'h4040_0000;
    scalar_load = 1'b1;
    vector_in   = line_b;
    step();
    quiet();
    chk("snap_a_scalar", LW'(mult_scalar), LW'(32'h3F00_0000));
    chk("snap_a_vector", mult_vector, line_a);
    step();
    chk("snap_b_scalar", LW'(mult_scalar), LW'(32'h4040_0000));
    chk("snap_b_vector", mult_vector, line_b);
    guard = 0;
    while (m_cred < CRED && guard < 50) begin
      credit_return = 1'b1;
      step();
      guard++;
    end
    credit_return = 1'b0;

    // Exhaust all credits, then overfill the FIFO with continuous pushes
    vector_valid = 1'b1;
    for (int i = 0; i < CRED; i++) begin
      vector_in = rand_line();
      step();
    end
    vector_valid = 1'b0;
    step();
    step();
    chk("exhaust_credits", LW'(credits), LW'(0));
    vector_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      vector_in = rand_line();
      step();
    end
    vector_valid = 1'b0;
    chk("full_fifo_count", LW'(fifo_count), LW'(DEPTH));
    chk("full_ready", LW'(vector_ready), LW'(0));
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    step();
    chk("one_credit_trigger", LW'(mult_trigger), LW'(1));
    step();
    chk("one_credit_only", LW'(mult_trigger), LW'(0));
    chk("one_credit_count", LW'(fifo_count), LW'(DEPTH - 1));
    guard = 0;
    while ((m_cred < CRED || mq.size() > 0) && guard < 100) begin
      credit_return = 1'b1;
      step();
      guard++;
    end
    credit_return = 1'b0;
    step();
    step();
    chk("drained_idle", LW'(idle), LW'(1));

    // Spurious return while idle: ignored, sticky overflow
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    chk("ovf_credits", LW'(credits), LW'(16));
    chk("ovf_set", LW'(credit_overflow), LW'(1));
    step();
    step();
    chk("ovf_sticky", LW'(credit_overflow), LW'(1));

    // Reset mid-operation with buffered lines and no credits
    reset = 1'b1;
    step();
    reset = 1'b0;
    vector_valid = 1'b1;
    for (int i = 0; i < CRED + 5; i++) begin
      vector_in = rand_line();
      step();
    end
    vector_valid = 1'b0;
    step();
    step();
    chk("pre_rst_count", LW'(fifo_count), LW'(5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_count", LW'(fifo_count), LW'(0));
    chk("mid_rst_credits", LW'(credits), LW'(16));
    chk("mid_rst_trigger", LW'(mult_trigger), LW'(0));
    chk("mid_rst_idle", LW'(idle), LW'(1));

    // Randomized traffic against the model, including one reset in the middle
    for (int i = 0; i < 500; i++) begin
      reset         = (i == 250);
      vector_valid  = ($urandom_range(0, 1) == 1);
      scalar_load   = ($urandom_range(0, 3) == 0);
      credit_return = ($urandom_range(0, 3) == 0);
      scalar_in     = $urandom;
      vector_in     = rand_line();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/float_svm_issue.md
FLOAT_SVM_ISSUE -- requirements
Module: float_svm_issue

Interface
REQ-001 Parameter VALUES_PER_LINE, default 16, meaning number of 32-bit floats per line.
REQ-002 Parameter FIFO_DEPTH, default 8, meaning number of input line entries; power of two, >= 2.
REQ-003 Parameter RESULT_CREDITS, default 16, meaning downstream result-buffer slots; range 1..255.
REQ-004 clk  input  1  rising-edge clock; one clock domain; reset is synchronous and active-high.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 scalar_in  input  32  IEEE-754 single scalar value.
REQ-007 scalar_load  input  1  capture scalar_in into the scalar register this cycle.
REQ-008 vector_in  input  32*VALUES_PER_LINE  input line; lane i at bits [32*i+31 : 32*i].
REQ-009 vector_valid  input  1  vector_in is valid this cycle.
REQ-010 vector_ready  output  1  block accepts a line this cycle; a line transfers when vector_valid && vector_ready.
REQ-011 mult_scalar  output  32  registered scalar for the multiplier stage.
REQ-012 mult_vector  output  32*VALUES_PER_LINE  registered line for the multiplier stage.
REQ-013 mult_trigger  output  1  registered one-cycle strobe; mult_scalar/mult_vector are valid for this cycle only.
REQ-014 credit_return  input  1  downstream freed one result slot this cycle.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of lines held in the FIFO.
REQ-016 credits  output  8  available result credits.
REQ-017 credit_overflow  output  1  sticky error flag.
REQ-018 idle  output  1  no buffered, issuing or in-flight work.

Function
REQ-019 Each FIFO entry SHALL store the line together with a snapshot of the effective scalar at accept time.
REQ-020 Effective scalar SHALL be scalar_in when scalar_load is high in the accept cycle, else the scalar register.
REQ-021 The scalar register SHALL update on every cycle with scalar_load high, independent of vector handshake.
REQ-022 vector_ready SHALL equal (fifo_count < FIFO_DEPTH); a pop in the same cycle does not raise it.
REQ-023 Issue condition per cycle: FIFO non-empty && credits > 0; when true the head entry is popped.
REQ-024 On issue, mult_scalar/mult_vector SHALL load the head entry and mult_trigger SHALL be 1 in the next cycle; otherwise mult_trigger 0 and mult_scalar/mult_vector hold.
REQ-025 Latency: line accepted in cycle t with FIFO empty and credits > 0 SHALL produce mult_trigger in cycle t+2.
REQ-026 Sustained throughput SHALL be one issue per cycle while FIFO non-empty and credits > 0.
REQ-027 Lines SHALL issue in strict acceptance order; no line dropped or duplicated.
REQ-028 credits: decrement by 1 on issue, increment by 1 on credit_return; both in one cycle leaves value unchanged.
REQ-029 credit_return with credits == RESULT_CREDITS and no issue that cycle SHALL be ignored and set credit_overflow.
REQ-030 credit_overflow SHALL remain 1 until reset.
REQ-031 Simultaneous push and pop SHALL leave fifo_count unchanged; push only +1, pop only -1.
REQ-032 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 idle SHALL equal (fifo_count == 0) && (credits == RESULT_CREDITS) && !mult_trigger, combinational from registers.

Reset
REQ-034 During reset: fifo_count 0, pointers 0, credits RESULT_CREDITS, mult_trigger 0, mult_scalar 0, mult_vector 0, scalar register 0, credit_overflow 0.
REQ-035 vector_ready SHALL be 0 in any cycle where reset is high; inputs are ignored in that cycle.
REQ-036 Reset mid-operation SHALL discard all buffered lines and outstanding credits; first post-reset accept follows REQ-025.

Verification
REQ-037 scalar_load 0x40000000, then push line lanes=0x3F800000 with credits=16 -> mult_trigger 2 cycles later, mult_scalar 0x40000000, all lanes 0x3F800000.
REQ-038 RESULT_CREDITS=4, push 6 lines, no credit_return -> exactly 4 triggers, credits 0, fifo_count 2; one credit_return -> one more trigger next cycle.
REQ-039 Hold credits 0, push FIFO_DEPTH+2 lines continuously -> vector_ready 0 after 8 accepts, fifo_count 8, no loss; restore credits -> 8 triggers in order.
REQ-040 Push line A (scalar S1), scalar_load S2 same cycle as line B accept -> A issues with S1, B with S2.
REQ-041 credit_return with credits 16 and idle -> credits stays 16, credit_overflow 1 until reset.
REQ-042 Reset asserted with fifo_count 5, credits 3 -> next cycle fifo_count 0, credits 16, mult_trigger 0, idle 1.
